// File: rtl/riscv_bpred_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encodings,
// table entry layout and init/run FSM states.
package riscv_bpred_pkg;

  localparam int unsigned BPRED_TAG_BITS = 8;
  localparam int unsigned BPRED_XLEN     = 32;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef struct packed {
    logic                      valid;
    logic [BPRED_TAG_BITS-1:0] tag;
    logic [1:0]                cnt;
    logic [BPRED_XLEN-1:0]     target;
  } bpred_entry_t;

  typedef enum logic {
    INIT,
    RUN
  } bpred_state_e;

endpackage

// File: rtl/riscv_sat_counter2.sv
// Combinational 2-bit saturating counter step: +1 on taken, -1 otherwise.
module riscv_sat_counter2
  import riscv_bpred_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// Direct-mapped BHT+BTB predictor with execute-stage training, redirect
// generation and an init sweep. Optional perf counters: RISCV_BPRED_STATS_EN.
module riscv_branch_predictor
  import riscv_bpred_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     stat_lookups_o,
  output logic [31:0]     stat_hits_o,
  output logic [31:0]     stat_mispredicts_o
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  // The entry struct is sized by the package; other widths cannot be stored.
  if (TAG_BITS != BPRED_TAG_BITS || XLEN != BPRED_XLEN) begin : g_bad_cfg
    $error("riscv_branch_predictor: TAG_BITS/XLEN must match riscv_bpred_pkg");
  end

  bpred_state_e        state_q;
  logic [IDX_BITS-1:0] idx_cnt_q;
  logic                ready_q;
  bpred_entry_t        table_q [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  bpred_entry_t        f_entry, u_entry, u_new;
  logic                u_hit, upd_write;
  logic [1:0]          cnt_next;
  logic [XLEN-1:0]     pc_plus4, actual_pc, predicted_pc;
  logic                unused_bits;

  assign f_idx   = fetch_pc_i[IDX_BITS+1:2];
  assign f_tag   = fetch_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign u_idx   = upd_pc_i[IDX_BITS+1:2];
  assign u_tag   = upd_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign f_entry = table_q[f_idx];
  assign u_entry = table_q[u_idx];

  assign unused_bits = ^{fetch_pc_i[XLEN-1:IDX_BITS+TAG_BITS+2],
                         fetch_pc_i[1:0], f_entry.cnt[0]};

  assign ready_o       = ready_q;
  assign pred_hit_o    = ready_q && f_entry.valid && (f_entry.tag == f_tag);
  assign pred_taken_o  = pred_hit_o && f_entry.cnt[1];
  assign pred_target_o = pred_hit_o ? f_entry.target : '0;

  riscv_sat_counter2 u_sat_counter (
    .cnt      (u_entry.cnt),
    .taken    (upd_taken_i),
    .cnt_next (cnt_next)
  );

  assign u_hit     = u_entry.valid && (u_entry.tag == u_tag);
  assign upd_write = upd_valid_i && !flush_i && (u_hit || upd_taken_i);

  always_comb begin
    u_new        = u_entry;
    u_new.valid  = 1'b1;
    u_new.tag    = u_tag;
    u_new.cnt    = u_hit ? cnt_next : CNT_WT;
    u_new.target = upd_taken_i ? upd_target_i : u_entry.target;
  end

  assign pc_plus4      = upd_pc_i + XLEN'(4);
  assign actual_pc     = upd_taken_i ? upd_target_i : pc_plus4;
  assign predicted_pc  = upd_pred_taken_i ? upd_pred_target_i : pc_plus4;
  assign mispredict_o  = upd_valid_i && (actual_pc != predicted_pc);
  assign redirect_pc_o = upd_valid_i ? actual_pc : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= INIT;
      idx_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (flush_i) begin
            idx_cnt_q <= '0;
          end else if (idx_cnt_q == IDX_BITS'(ENTRIES - 1)) begin
            idx_cnt_q <= '0;
            state_q   <= RUN;
            ready_q   <= 1'b1;
          end else begin
            idx_cnt_q <= idx_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (flush_i) begin
            idx_cnt_q <= '0;
            state_q   <= INIT;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Table storage has no reset; validity is established by the sweep.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state_q == INIT) begin
        table_q[idx_cnt_q].valid <= 1'b0;
      end else if (upd_write) begin
        table_q[u_idx] <= u_new;
      end
    end
  end

`ifdef RISCV_BPRED_STATS_EN
  logic [31:0] lookups_q, hits_q, mispredicts_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lookups_q     <= '0;
      hits_q        <= '0;
      mispredicts_q <= '0;
    end else if (state_q == RUN) begin
      if (lookups_q != '1) lookups_q <= lookups_q + 32'd1;
      if (pred_hit_o && hits_q != '1) hits_q <= hits_q + 32'd1;
      if (mispredict_o && mispredicts_q != '1) mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign stat_lookups_o     = lookups_q;
  assign stat_hits_o        = hits_q;
  assign stat_mispredicts_o = mispredicts_q;
`else
  assign stat_lookups_o     = '0;
  assign stat_hits_o        = '0;
  assign stat_mispredicts_o = '0;
`endif

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed scoreboard bench for riscv_branch_predictor (default parameters).
module tb_riscv_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_ni, flush_i, ready_o;
  logic [31:0] fetch_pc_i, pred_target_o, redirect_pc_o;
  logic        pred_hit_o, pred_taken_o, mispredict_o;
  logic        upd_valid_i, upd_taken_i, upd_pred_taken_i;
  logic [31:0] upd_pc_i, upd_target_i, upd_pred_target_i;
  logic [31:0] stat_lookups_o, stat_hits_o, stat_mispredicts_o;

  riscv_branch_predictor #(.IDX_BITS(6), .TAG_BITS(8), .XLEN(32)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .ready_o            (ready_o),
    .fetch_pc_i         (fetch_pc_i),
    .pred_hit_o         (pred_hit_o),
    .pred_taken_o       (pred_taken_o),
    .pred_target_o      (pred_target_o),
    .upd_valid_i        (upd_valid_i),
    .upd_pc_i           (upd_pc_i),
    .upd_taken_i        (upd_taken_i),
    .upd_target_i       (upd_target_i),
    .upd_pred_taken_i   (upd_pred_taken_i),
    .upd_pred_target_i  (upd_pred_target_i),
    .mispredict_o       (mispredict_o),
    .redirect_pc_o      (redirect_pc_o),
    .stat_lookups_o     (stat_lookups_o),
    .stat_hits_o        (stat_hits_o),
    .stat_mispredicts_o (stat_mispredicts_o)
  );

  always #5 clk = ~clk;

  typedef enum int {O_READY, O_HIT, O_TAKEN, O_TARGET, O_MISP, O_REDIR,
                    O_SLOOK, O_SHIT, O_SMISP} obs_e;
  typedef struct {
    obs_e        id;
    logic [31:0] val;
  } exp_t;

  exp_t queue_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] observe(input obs_e id);
    case (id)
      O_READY:  return {31'd0, ready_o};
      O_HIT:    return {31'd0, pred_hit_o};
      O_TAKEN:  return {31'd0, pred_taken_o};
      O_TARGET: return pred_target_o;
      O_MISP:   return {31'd0, mispredict_o};
      O_REDIR:  return redirect_pc_o;
      O_SLOOK:  return stat_lookups_o;
      O_SHIT:   return stat_hits_o;
      default:  return stat_mispredicts_o;
    endcase
  endfunction

  task automatic push(input obs_e id, input logic [31:0] val);
    exp_t e;
    e.id  = id;
    e.val = val;
    queue_q.push_back(e);
  endtask

  task automatic check(input string step);
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (queue_q.size() > 0) begin
      e   = queue_q.pop_front();
      obs = observe(e.id);
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s/%s: observed %h expected %h", step, e.id.name(), obs, e.val);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    upd_valid_i       = v;
    upd_pc_i          = pc;
    upd_taken_i       = t;
    upd_target_i      = tgt;
    upd_pred_taken_i  = pt;
    upd_pred_target_i = ptgt;
  endtask

  task automatic idle_upd;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic lookup(input string step, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
    fetch_pc_i = pc;
    push(O_HIT, {31'd0, hit});
    push(O_TAKEN, {31'd0, taken});
    push(O_TARGET, tgt);
    check(step);
  endtask

  // Drive one update for a cycle, check its combinational outputs, then apply it.
  task automatic update(input string step, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                        input logic misp, input logic [31:0] redir);
    set_upd(1'b1, pc, t, tgt, pt, ptgt);
    push(O_MISP, {31'd0, misp});
    push(O_REDIR, redir);
    check(step);
    tick;
    idle_upd;
  endtask

  task automatic check_stats_zero(input string step);
`ifndef RISCV_BPRED_STATS_EN
    push(O_SLOOK, 32'd0);
    push(O_SHIT, 32'd0);
    push(O_SMISP, 32'd0);
    check(step);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    fetch_pc_i = 32'h0;
    idle_upd;
    tick;
    tick;
    push(O_READY, 32'd0);
    push(O_HIT, 32'd0);
    push(O_MISP, 32'd0);
    push(O_REDIR, 32'd0);
    push(O_SLOOK, 32'd0);
    push(O_SHIT, 32'd0);
    push(O_SMISP, 32'd0);
    check("reset");

    rst_ni = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick;
      if (i == 1) begin
        lookup("init_lookup", 32'h100, 1'b0, 1'b0, 32'h0);
        // Update during INIT: flags mispredict but must not be written.
        set_upd(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
        push(O_MISP, 32'd1);
        push(O_REDIR, 32'h40);
        check("init_misp");
      end
      if (i == 2) idle_upd;
      push(O_READY, {31'd0, i == 64});
      check($sformatf("sweep_%0d", i));
    end
`ifdef RISCV_BPRED_STATS_EN
    push(O_SLOOK, 32'd0);
    push(O_SHIT, 32'd0);
    push(O_SMISP, 32'd0);
    check("stats_after_init");
`endif

    lookup("init_upd_dropped", 32'h100, 1'b0, 1'b0, 32'h0);

    // Allocate 0x100; same-cycle lookup still sees the old (invalid) entry.
    fetch_pc_i = 32'h100;
    push(O_HIT, 32'd0);
    check("no_bypass");
    update("alloc", 32'h100, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h40);
    lookup("alloc_hit", 32'h100, 1'b1, 1'b1, 32'h40);

    update("t1", 32'h100, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
    update("t2", 32'h100, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
    lookup("cnt_st", 32'h100, 1'b1, 1'b1, 32'h40);
    update("nt1", 32'h100, 1'b0, 32'h999, 1'b1, 32'h40, 1'b1, 32'h104);
    lookup("cnt_wt", 32'h100, 1'b1, 1'b1, 32'h40);
    update("nt2", 32'h100, 1'b0, 32'h999, 1'b1, 32'h40, 1'b1, 32'h104);
    lookup("cnt_wnt", 32'h100, 1'b1, 1'b0, 32'h40);
    update("nt3", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104);
    lookup("cnt_snt", 32'h100, 1'b1, 1'b0, 32'h40);
    update("nt4", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104);
    lookup("cnt_snt_sat", 32'h100, 1'b1, 1'b0, 32'h40);
    update("t_from_snt", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup("cnt_wnt_again", 32'h100, 1'b1, 1'b0, 32'h80);
    update("t_to_wt", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    lookup("cnt_wt_again", 32'h100, 1'b1, 1'b1, 32'h80);

    lookup("alias_miss", 32'h200, 1'b0, 1'b0, 32'h0);
    update("alias_alloc", 32'h200, 1'b1, 32'h500, 1'b1, 32'h500, 1'b0, 32'h500);
    lookup("alias_new", 32'h200, 1'b1, 1'b1, 32'h500);
    lookup("alias_evicted", 32'h100, 1'b0, 1'b0, 32'h0);

    update("nt_miss", 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h304);
    lookup("nt_no_alloc", 32'h300, 1'b0, 1'b0, 32'h0);
    lookup("nt_no_evict", 32'h200, 1'b1, 1'b1, 32'h500);
    update("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    update("wrap_pred", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);

    set_upd(1'b0, 32'h300, 1'b1, 32'h700, 1'b0, 32'h0);
    push(O_MISP, 32'd0);
    push(O_REDIR, 32'd0);
    check("upd_invalid");
    idle_upd;
    check_stats_zero("stats_tied");

    // Flush with a simultaneous taken update: flush wins.
    flush_i = 1'b1;
    set_upd(1'b1, 32'h400, 1'b1, 32'h900, 1'b0, 32'h0);
    tick;
    flush_i = 1'b0;
    idle_upd;
    for (int i = 1; i <= 64; i++) begin
      push(O_READY, 32'd0);
      check($sformatf("flush_low_%0d", i));
      tick;
    end
    push(O_READY, 32'd1);
    check("flush_ready");
    lookup("flush_drop", 32'h400, 1'b0, 1'b0, 32'h0);
    lookup("flush_inval", 32'h200, 1'b0, 1'b0, 32'h0);
    check_stats_zero("stats_tied_end");

    // Reset mid-RUN returns to INIT on that edge.
    rst_ni = 1'b0;
    tick;
    rst_ni = 1'b1;
    push(O_READY, 32'd0);
    check("reset_mid_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_branch_predictor.md
# riscv_branch_predictor

Fetch-stage dynamic branch predictor: a direct-mapped table of 2-bit saturating counters with tag and target (BHT + BTB in one entry), looked up with the fetch PC. It is trained from the execute stage by the resolved branch outcome, i.e. the `pcsrc` decision and branch target. The block also compares the resolved next-PC against the prediction that travelled down the pipe and raises a redirect on mismatch. After reset or flush, an init FSM sweeps the table invalid one entry per cycle.

## Interface
- `IDX_BITS`, 6, log2 of table entries (64)
- `TAG_BITS`, 8, tag width per entry
- `XLEN`, 32, PC/target width
- `clk_i` in 1: clock, rising edge
- `rst_ni` in 1: reset, synchronous, active-low
- `flush_i` in 1: invalidate whole table (re-enter INIT)
- `ready_o` out 1: table initialised; predictions/updates honoured
- `fetch_pc_i` in XLEN: lookup PC
- `pred_hit_o` out 1: valid entry with matching tag
- `pred_taken_o` out 1: hit and counter MSB = 1
- `pred_target_o` out XLEN: entry target on hit, else 0
- `upd_valid_i` in 1: resolved branch this cycle
- `upd_pc_i` in XLEN: PC of resolved branch
- `upd_taken_i` in 1: actual outcome (pcsrc)
- `upd_target_i` in XLEN: computed branch target
- `upd_pred_taken_i` in 1: prediction carried with the instruction
- `upd_pred_target_i` in XLEN: predicted target carried with the instruction
- `mispredict_o` out 1: predicted next-PC ≠ actual next-PC
- `redirect_pc_o` out XLEN: actual next-PC
- `stat_lookups_o`, `stat_hits_o`, `stat_mispredicts_o` out 32 each: performance counters (see Configuration)

## Operation
- Index = PC[IDX_BITS+1:2]. Tag = PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Each entry holds valid, tag, 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST) and target.
- FSM states:
  - INIT: clears `valid[idx_cnt]` each cycle, increments `idx_cnt`, and goes to RUN after entry 2^IDX_BITS−1 is cleared.
  - RUN: `flush_i` → INIT with `idx_cnt`=0.
- Lookup is combinational from table state. In INIT, `pred_hit_o` = `pred_taken_o` = 0 and `pred_target_o` = 0.
- Update applies in RUN only and is ignored in INIT:
  - Hit, taken: counter saturating +1; target ← `upd_target_i`.
  - Hit, not taken: counter saturating −1; target unchanged.
  - Miss, taken: allocate (valid=1, tag, counter=10, target). This overwrites any aliasing entry.
  - Miss, not taken: no write.
- Misprediction check:
  - actual = `upd_taken_i` ? `upd_target_i` : `upd_pc_i`+4.
  - predicted = `upd_pred_taken_i` ? `upd_pred_target_i` : `upd_pc_i`+4.
  - `mispredict_o` = `upd_valid_i` & (actual ≠ predicted). It is combinational and also valid during INIT.
  - `redirect_pc_o` = actual, or 0 when `upd_valid_i`=0.
- PC+4 wraps modulo 2^XLEN.

## Timing
- Reset (`rst_ni`=0 at an edge): state INIT, `idx_cnt`=0, `ready_o`=0, all stat counters 0.
  - Combinational outputs are 0 while inputs are idle.
  - Valid bits are cleared by the sweep, not by reset.
- `ready_o` rises exactly 2^IDX_BITS cycles after the first edge with `rst_ni`=1.
- A table write is visible to lookup on the cycle after the update edge. There is no same-cycle bypass: a lookup to the entry being updated sees old contents.
- Simultaneous events:
  - `flush_i` together with `upd_valid_i` in RUN: flush wins and the update is dropped.
  - `flush_i` in INIT restarts the sweep at 0.
- Reset asserted mid-sweep or mid-RUN: return to INIT on that edge.

## Configuration
- `RISCV_BPRED_STATS_EN` defined:
  - Three 32-bit saturating counters, incremented in RUN only:
    - lookups: every cycle.
    - hits: every cycle with `pred_hit_o`.
    - mispredicts: every cycle with `mispredict_o`.
  - All three clear on reset; `flush_i` does not clear them.
- Macro not defined: the stat ports remain present, tied to 0, and no counter logic is generated.

## Structure
- `riscv_bpred_pkg` holds:
  - counter encodings `CNT_SNT`/`CNT_WNT`/`CNT_WT`/`CNT_ST`;
  - the entry struct typedef (valid, tag, cnt, target);
  - the FSM state enum (INIT, RUN).
- Sub-module `riscv_sat_counter2`: combinational 2-bit saturating inc/dec (inputs cnt, taken; output next cnt).

## Test plan
- Reset release with default parameters → `ready_o`=0 for 64 cycles and =1 on cycle 64; lookup 0x100 during INIT → hit=0, taken=0.
- Update pc=0x100, taken, target=0x40, pred_taken=0 → `mispredict_o`=1, `redirect_pc_o`=0x40; next-cycle lookup 0x100 → hit=1, taken=1, target=0x40.
- Counter saturation on the 0x100 entry:
  - Two more taken updates → counter 11.
  - First not-taken update → still predicts taken (counter 10).
  - Second not-taken update → predicts not taken (counter 01).
  - Third not-taken update → counter 00; a fourth not-taken update → stays 00.
- Alias: after allocating 0x100, lookup 0x200 (same index 0, tag 0x02 vs 0x01) → hit=0; taken update of 0x200 evicts the entry, and lookup 0x100 then misses.
- Update pc=0x300, not taken, pred_taken=0 → `mispredict_o`=0, `redirect_pc_o`=0x304, no allocation; pc=0xFFFFFFFC not-taken → `redirect_pc_o`=0x0.
- `flush_i` in RUN with a simultaneous update → `ready_o` low for 64 cycles, the update is dropped, and all lookups miss afterwards; with `RISCV_BPRED_STATS_EN` the stat counters are unchanged by the flush.
